// File: rtl/alu_cmd_driver_if.sv
// alu_cmd_driver_if: command, ALU beat and response signals of the ALU command driver
interface alu_cmd_driver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic                  alu_opcode_valid;
    logic                  alu_opcode;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_done;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_overflow;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_overflow;
    logic                  rsp_timeout;
    logic                  spurious_done;
    logic [15:0]           op_count;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, alu_overflow, rsp_ready,
        input  cmd_ready, alu_opcode_valid, alu_opcode, alu_data,
               rsp_valid, rsp_result, rsp_overflow, rsp_timeout, spurious_done, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, alu_overflow, rsp_ready,
        output cmd_ready, alu_opcode_valid, alu_opcode, alu_data,
               rsp_valid, rsp_result, rsp_overflow, rsp_timeout, spurious_done, op_count
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: serializes one ALU command into three beats and holds the ALU response
module alu_cmd_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 32
) (
    input logic clk,
    input logic reset_n,
    alu_cmd_driver_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT_A, S_BEAT_B, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_overflow;
    logic                  r_timeout;
    logic                  r_spurious;
    logic [7:0]            r_wait_cnt;
    logic [15:0]           r_op_count;
    logic                  w_timeout_hit;
    logic                  w_alu_valid;
    logic                  w_alu_opcode;
    logic [DATA_WIDTH-1:0] w_alu_data;

    assign w_timeout_hit = r_wait_cnt == 8'(TIMEOUT - 1);

    // state register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next state and beat decode; beats come only from state and the latched command
    always_comb begin
        w_next       = r_state;
        w_alu_valid  = 1'b0;
        w_alu_opcode = 1'b0;
        w_alu_data   = '0;
        case (r_state)
            S_IDLE:   if (bus.cmd_valid) w_next = S_BEAT0;
            S_BEAT0:  begin
                w_alu_valid = 1'b1;
                w_next      = S_BEAT_A;
            end
            S_BEAT_A: begin
                w_alu_valid  = 1'b1;
                w_alu_opcode = r_op[0];
                w_alu_data   = r_a;
                w_next       = S_BEAT_B;
            end
            S_BEAT_B: begin
                w_alu_valid  = 1'b1;
                w_alu_opcode = r_op[1];
                w_alu_data   = r_b;
                w_next       = S_WAIT;
            end
            S_WAIT:   if (bus.alu_done || w_timeout_hit) w_next = S_RESP;
            S_RESP:   if (bus.rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // command latch, wait watchdog, response capture, spurious flag and op counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_wait_cnt <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_spurious <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (r_state == S_IDLE && bus.cmd_valid) begin
                r_op <= bus.cmd_op;
                r_a  <= bus.cmd_a;
                r_b  <= bus.cmd_b;
            end
            if (r_state == S_BEAT_B)    r_wait_cnt <= '0;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_state == S_WAIT && (bus.alu_done || w_timeout_hit)) begin
                r_result   <= bus.alu_done ? bus.alu_result : '0;
                r_overflow <= bus.alu_done && bus.alu_overflow;
                r_timeout  <= !bus.alu_done;
            end
            if (bus.alu_done && r_state != S_WAIT) r_spurious <= 1'b1;
            if (r_state == S_RESP && bus.rsp_ready) r_op_count <= r_op_count + 16'd1;
        end
    end

    assign bus.cmd_ready        = r_state == S_IDLE;
    assign bus.alu_opcode_valid = w_alu_valid;
    assign bus.alu_opcode       = w_alu_opcode;
    assign bus.alu_data         = w_alu_data;
    assign bus.rsp_valid        = r_state == S_RESP;
    assign bus.rsp_result       = r_result;
    assign bus.rsp_overflow     = r_overflow;
    assign bus.rsp_timeout      = r_timeout;
    assign bus.spurious_done    = r_spurious;
    assign bus.op_count         = r_op_count;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed checks of beats, responses, watchdog, spurious flag and reset
module tb_alu_cmd_driver;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    alu_cmd_driver_if #(.DATA_WIDTH(8)) bus ();

    alu_cmd_driver #(.DATA_WIDTH(8), .TIMEOUT(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_beat(input string tag, input logic op, input logic [7:0] data);
        chk({tag, "_valid"}, bus.alu_opcode_valid, 1);
        chk({tag, "_opcode"}, bus.alu_opcode, op);
        chk({tag, "_data"}, bus.alu_data, data);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_alu_valid"}, bus.alu_opcode_valid, 0);
        chk({tag, "_alu_opcode"}, bus.alu_opcode, 0);
        chk({tag, "_alu_data"}, bus.alu_data, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 0);
        chk({tag, "_rsp_overflow"}, bus.rsp_overflow, 0);
        chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
        chk({tag, "_spurious"}, bus.spurious_done, 0);
        chk({tag, "_op_count"}, bus.op_count, 0);
    endtask

    // called at an IDLE negedge; returns at the negedge of the first WAIT cycle
    task automatic issue(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        chk({tag, "_ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_a     = 8'hEE;
        bus.cmd_b     = 8'hDD;
        chk({tag, "_busy"}, bus.cmd_ready, 0);
        chk_beat({tag, "_b0"}, 1'b0, 8'h00);
        step();
        chk_beat({tag, "_ba"}, op[0], a);
        step();
        chk_beat({tag, "_bb"}, op[1], b);
        step();
        chk({tag, "_wait_valid"}, bus.alu_opcode_valid, 0);
    endtask

    // done seen in the k-th WAIT cycle; returns at the first RESP negedge
    task automatic finish_op(input string tag, input int k, input logic [7:0] res, input logic ovf);
        repeat (k - 1) begin
            chk({tag, "_not_yet"}, bus.rsp_valid, 0);
            step();
        end
        chk({tag, "_not_yet"}, bus.rsp_valid, 0);
        bus.alu_done     = 1'b1;
        bus.alu_result   = res;
        bus.alu_overflow = ovf;
        step();
        bus.alu_done     = 1'b0;
        bus.alu_result   = 8'hAA;
        bus.alu_overflow = 1'b1;
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, "_rsp_result"}, bus.rsp_result, res);
        chk({tag, "_rsp_overflow"}, bus.rsp_overflow, ovf);
        chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
    endtask

    task automatic handshake(input string tag, input logic [15:0] count);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_dropped"}, bus.rsp_valid, 0);
        chk({tag, "_op_count"}, bus.op_count, count);
        chk({tag, "_idle_ready"}, bus.cmd_ready, 1);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 2'b00;
        bus.cmd_a        = 8'h00;
        bus.cmd_b        = 8'h00;
        bus.alu_done     = 1'b0;
        bus.alu_result   = 8'h00;
        bus.alu_overflow = 1'b0;
        bus.rsp_ready    = 1'b0;
        step();
        step();
        chk_reset_state("rst");
        reset_n = 1'b1;
        step();

        issue("add", 2'b00, 8'h05, 8'h03);
        finish_op("add", 4, 8'h08, 1'b0);
        handshake("add", 16'd1);

        issue("sub", 2'b01, 8'h80, 8'h01);
        finish_op("sub", 2, 8'h7F, 1'b1);
        handshake("sub", 16'd2);

        issue("bp", 2'b10, 8'h0F, 8'hF0);
        finish_op("bp", 1, 8'h04, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid = i[0];
            bus.cmd_op    = i[1:0];
            bus.cmd_a     = 8'(i * 7);
            bus.cmd_b     = 8'(i * 3);
            step();
            chk("bp_hold_valid", bus.rsp_valid, 1);
            chk("bp_hold_result", bus.rsp_result, 8'h04);
            chk("bp_hold_overflow", bus.rsp_overflow, 0);
            chk("bp_hold_timeout", bus.rsp_timeout, 0);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_no_beat", bus.alu_opcode_valid, 0);
            chk("bp_op_count", bus.op_count, 16'd2);
        end
        bus.cmd_valid = 1'b0;
        handshake("bp", 16'd3);
        issue("comp", 2'b11, 8'h12, 8'h34);
        finish_op("comp", 1, 8'h01, 1'b0);
        handshake("comp", 16'd4);

        issue("to", 2'b00, 8'h01, 8'h02);
        bus.alu_result = 8'h55;
        repeat (31) begin
            chk("to_waiting", bus.rsp_valid, 0);
            step();
        end
        chk("to_last_wait", bus.rsp_valid, 0);
        step();
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_timeout", bus.rsp_timeout, 1);
        chk("to_rsp_result", bus.rsp_result, 0);
        chk("to_rsp_overflow", bus.rsp_overflow, 0);
        handshake("to", 16'd5);

        chk("sp_before", bus.spurious_done, 0);
        bus.alu_done = 1'b1;
        step();
        bus.alu_done = 1'b0;
        chk("sp_set", bus.spurious_done, 1);
        chk("sp_still_idle", bus.cmd_ready, 1);
        issue("sp_cmd", 2'b00, 8'h01, 8'h01);
        finish_op("sp_cmd", 1, 8'h02, 1'b0);
        handshake("sp_cmd", 16'd6);
        chk("sp_sticky", bus.spurious_done, 1);

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_a     = 8'h33;
        bus.cmd_b     = 8'h44;
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk_beat("mid_ba", 1'b1, 8'h33);
        reset_n = 1'b0;
        step();
        chk_reset_state("mid_rst");
        reset_n = 1'b1;
        step();
        chk("mid_no_beat", bus.alu_opcode_valid, 0);
        chk("mid_no_rsp", bus.rsp_valid, 0);
        issue("post", 2'b01, 8'h10, 8'h20);
        finish_op("post", 1, 8'hF0, 1'b0);
        handshake("post", 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Upstream command stage for `simple_alu`. It accepts one ALU command (2-bit opcode plus operands A and B) on a valid/ready interface and serializes it onto the ALU's three-beat `opcode_valid`/`opcode`/`data` protocol. It then waits for the ALU `done` pulse, captures `result` and `overflow`, and holds them on a response valid/ready interface. A wait-cycle watchdog, a spurious-done flag and a completed-operation counter support bring-up and verification.

## Interface
- `DATA_WIDTH`, 8, operand/result width; must match `simple_alu`.
- `TIMEOUT`, 32, maximum cycles in WAIT before the command is abandoned; legal range 2..255.
- `clk`  in  1  clock; all logic rises on posedge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_op`  in  2  00 ADD, 01 SUB, 10 PAR, 11 COMP.
- `cmd_a`, `cmd_b`  in  DATA_WIDTH  operands.
- `alu_opcode_valid`  out  1  to ALU `opcode_valid`.
- `alu_opcode`  out  1  to ALU `opcode`.
- `alu_data`  out  DATA_WIDTH  to ALU `data`.
- `alu_done`  in  1  from ALU `done`.
- `alu_result`  in  DATA_WIDTH  from ALU `result`.
- `alu_overflow`  in  1  from ALU `overflow`.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  DATA_WIDTH  captured result.
- `rsp_overflow`  out  1  captured overflow.
- `rsp_timeout`  out  1  response produced by the watchdog, not by `alu_done`.
- `spurious_done`  out  1  sticky; set when `alu_done` is seen outside WAIT.
- `op_count`  out  16  completed responses (handshaken), wraps.

## Operation
- States: IDLE, BEAT0, BEAT_A, BEAT_B, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch op/A/B, go to BEAT0.
- BEAT0:
  - `alu_opcode_valid`=1, `alu_opcode`=0, `alu_data`=0.
  - Moves the ALU from IDLE to DATA_A.
  - Next state BEAT_A.
- BEAT_A:
  - `alu_opcode_valid`=1, `alu_opcode`=op[0], `alu_data`=A.
  - Next state BEAT_B.
- BEAT_B:
  - `alu_opcode_valid`=1, `alu_opcode`=op[1], `alu_data`=B.
  - Next state WAIT; clear the wait counter.
- WAIT:
  - ALU outputs all 0.
  - The wait counter increments every cycle.
  - `alu_done`=1: capture `alu_result`/`alu_overflow` and set timeout=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: capture result=0, overflow=0, timeout=1, go to RESP.
  - `alu_done` wins if it arrives in that same cycle.
- RESP:
  - `rsp_valid`=1; response fields stable.
  - On `rsp_ready`: increment `op_count` (wrap 0xFFFF→0) and go to IDLE.
- In all states other than BEAT0/BEAT_A/BEAT_B, `alu_opcode_valid`, `alu_opcode` and `alu_data` are 0.
- `alu_done`=1 in any state except WAIT sets `spurious_done`. Only reset clears it.
- `cmd_valid` is ignored outside IDLE; the latched command is never overwritten mid-transaction.
- `op_count` increments only on the RESP handshake, timeouts included.

## Timing
- Reset (`reset_n`=0 at a clock edge): state becomes IDLE. Resulting output values:
  - `cmd_ready`=1.
  - All `alu_*` outputs = 0.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_overflow`=0, `rsp_timeout`=0.
  - `spurious_done`=0, `op_count`=0.
- Reset mid-transaction aborts immediately. No beats follow, and no response is produced.
- All outputs are registered or decoded from state only; no input→output combinational path.
- Cycle sequence for a command accepted at edge t:
  - Beats are driven in cycles t+1, t+2, t+3.
  - WAIT begins at cycle t+4.
  - `alu_done` seen in cycle t+3+k (k≥1) gives `rsp_valid`=1 from cycle t+4+k.
- With `rsp_ready` tied high, `rsp_valid` lasts one cycle and `cmd_ready` returns the next cycle. Back-to-back throughput is 1 command per (5+k) cycles.
- Timeout: with no `alu_done`, `rsp_valid` rises TIMEOUT cycles after WAIT entry.

## Test plan
- ADD: `cmd_op`=00, A=8'h05, B=8'h03. ALU model pulses done 4 cycles after the last beat with result 8'h08.
  - Beats must be (1,0,00), (1,0,05), (1,0,03).
  - Response: `rsp_result`=8'h08, `rsp_overflow`=0, `rsp_timeout`=0, `op_count`=1.
- SUB overflow: `cmd_op`=01, A=8'h80, B=8'h01. Model returns result 8'h7F, overflow=1.
  - Beats carry opcode bits 1 then 0.
  - Response: `rsp_overflow`=1, `rsp_result`=8'h7F.
- Backpressure: hold `rsp_ready`=0 for 10 cycles, toggling `cmd_valid` with new commands throughout.
  - `rsp_*` stays stable, `cmd_ready` stays 0 and no beats are emitted.
  - After `rsp_ready`=1, the next command is accepted.
- Timeout: TIMEOUT=32, model never asserts done.
  - `rsp_valid` rises exactly 32 cycles after WAIT entry with `rsp_timeout`=1 and `rsp_result`=0.
  - `op_count` increments on the handshake.
- Spurious done: pulse `alu_done` while IDLE.
  - `spurious_done`=1 next cycle and remains 1 across further commands until reset.
- Reset mid-op: assert `reset_n`=0 during BEAT_A.
  - Next cycle all outputs are at their reset values.
  - `op_count` is 0, and the next command produces a clean 3-beat sequence.
